note_lane_scroller: RTL and testbench

NOTE_LANE_SCROLLER -- requirements
Module: note_lane_scroller

---
 rtl/gv_pkg.sv | 36 +++
 rtl/beat_tick_gen.sv | 53 +++++
 rtl/note_lane_scroller.sv | 141 ++++++++++++++
 tb/tb_note_lane_scroller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gv_pkg
//  Purpose  : Shared widths, lane indices, scroller state enum and the beat
//             period clamp used by the note lane scroller.
//  Revision : 1.0 - initial release
// ============================================================================
package gv_pkg;

  localparam int LANE_W   = 39;  // lane width
  localparam int CNT_W    = 23;  // beat counter width
  localparam int HIT_IDX  = 37;  // hit-zone bit of the lane
  localparam int EXIT_IDX = 38;  // exit slot, discarded on the next shift
  localparam int DRAIN_W  = 6;   // wide enough to hold LANE_W

  // Zero-shifts needed to flush every note out through the exit slot
  localparam logic [DRAIN_W-1:0] DRAIN_LEN = 6'd39;

  // Shortest usable beat period; shorter requests are stretched to this
  localparam logic [CNT_W-1:0]   LIM_MIN   = 23'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } scroll_state_t;

  // A beat period below 2 would make every cycle a tick; clamp it.
  function automatic logic [CNT_W-1:0] clamp_lim(input logic [CNT_W-1:0] lim);
    return (lim < LIM_MIN) ? LIM_MIN : lim;
  endfunction

endpackage
`default_nettype wire

// File: rtl/beat_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : beat_tick_gen
//  Purpose  : Beat counter with latched, clamped period. Counts while enabled,
//             flags the last cycle of each beat and wraps to zero on it.
//  Revision : 1.0 - initial release
// ============================================================================
module beat_tick_gen
  import gv_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load_i,   // song start accepted: latch period, clear count
  input  logic [CNT_W-1:0] lim_i,
  input  logic             en_i,     // advance the counter this cycle
  output logic [CNT_W-1:0] count_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] C_ONE = 23'd1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;

  // Tick is the final cycle of the beat; period only changes on load
  assign tick_o  = (cnt_q == (lim_q - C_ONE));
  assign count_o = cnt_q;

  // Next-state for the counter and latched period
  always_comb begin
    cnt_d = cnt_q;
    lim_d = lim_q;
    if (load_i) begin
      cnt_d = '0;
      lim_d = clamp_lim(lim_i);
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : (cnt_q + C_ONE);
    end
  end

  // Counter and period registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
      lim_q <= LIM_MIN;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/note_lane_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : note_lane_scroller
//  Purpose  : Scrolls song notes through a 39-bit lane, one slot per beat,
//             with pause, underrun detection and a drain phase that flushes
//             the lane after the last note.
//  Revision : 1.0 - initial release
// ============================================================================
module note_lane_scroller
  import gv_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              pause,
  input  logic [CNT_W-1:0]  lim,
  input  logic              note_valid,
  input  logic              note_bit,
  input  logic              note_last,
  output logic              note_ready,
  output logic [LANE_W-1:0] padded_notes,
  output logic [CNT_W-1:0]  counter,
  output logic              playing,
  output logic              song_done,
  output logic              underrun
);

  localparam logic [DRAIN_W-1:0] C_DRAIN_ONE = 6'd1;

  scroll_state_t state_q, state_d;

  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               underrun_q, underrun_d;
  logic               song_done_q;
  logic               playing_q;

  logic               w_tick;
  logic               w_start_acc;
  logic               w_cnt_en;
  logic               w_shift;
  logic               w_in_bit;
  logic               w_note_ready;

  beat_tick_gen u_beat (
    .clk     (clk),
    .n_rst   (n_rst),
    .load_i  (w_start_acc),
    .lim_i   (lim),
    .en_i    (w_cnt_en),
    .count_o (counter),
    .tick_o  (w_tick)
  );

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; pause beats a same-cycle tick in PLAY
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_PLAY;
      ST_PLAY: begin
        if (pause)
          state_d = ST_PAUSE;
        else if (w_tick && note_valid && note_last)
          state_d = ST_DRAIN;
      end
      ST_PAUSE: if (!pause) state_d = ST_PLAY;
      ST_DRAIN: if (w_tick && (drain_cnt_q == C_DRAIN_ONE)) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Per-state control strobes: counting, shifting and the injected bit
  always_comb begin
    w_start_acc  = 1'b0;
    w_cnt_en     = 1'b0;
    w_note_ready = 1'b0;
    w_in_bit     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: w_start_acc = start;
      ST_PLAY: begin
        w_cnt_en     = !pause;
        w_note_ready = !pause && w_tick;
        w_in_bit     = note_valid & note_bit;
      end
      ST_DRAIN: w_cnt_en = 1'b1;
      default: ;
    endcase
    w_shift = w_cnt_en && w_tick;
  end

  // Lane, drain countdown and sticky underrun next-state
  always_comb begin
    lane_d      = lane_q;
    drain_cnt_d = drain_cnt_q;
    underrun_d  = underrun_q;
    if (w_start_acc) begin
      lane_d     = '0;
      underrun_d = 1'b0;
    end else if (w_shift) begin
      lane_d = {lane_q[HIT_IDX:0], w_in_bit};
      if (state_q == ST_PLAY) begin
        if (!note_valid)    underrun_d  = 1'b1;
        else if (note_last) drain_cnt_d = DRAIN_LEN;
      end else begin
        drain_cnt_d = drain_cnt_q - C_DRAIN_ONE;
      end
    end
  end

  // Datapath registers; song_done pulses only on the cycle DONE is entered
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lane_q      <= '0;
      drain_cnt_q <= '0;
      underrun_q  <= 1'b0;
      song_done_q <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      drain_cnt_q <= drain_cnt_d;
      underrun_q  <= underrun_d;
      song_done_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
      playing_q   <= (state_d == ST_PLAY) || (state_d == ST_PAUSE) ||
                     (state_d == ST_DRAIN);
    end
  end

  assign note_ready   = w_note_ready;
  assign padded_notes = lane_q;
  assign playing      = playing_q;
  assign song_done    = song_done_q;
  assign underrun     = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_note_lane_scroller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_note_lane_scroller
//  Purpose  : Directed self-checking bench for note_lane_scroller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_note_lane_scroller;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic        pause;
  logic [22:0] lim;
  logic        note_valid;
  logic        note_bit;
  logic        note_last;
  logic        note_ready;
  logic [38:0] padded_notes;
  logic [22:0] counter;
  logic        playing;
  logic        song_done;
  logic        underrun;

  int n_checks = 0;
  int n_fail   = 0;

  note_lane_scroller dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .pause        (pause),
    .lim          (lim),
    .note_valid   (note_valid),
    .note_bit     (note_bit),
    .note_last    (note_last),
    .note_ready   (note_ready),
    .padded_notes (padded_notes),
    .counter      (counter),
    .playing      (playing),
    .song_done    (song_done),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
    end
  endtask

  // Advance n rising edges, leaving 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".counter"},    64'(counter),      64'd0);
    chk({tag, ".lane"},       64'(padded_notes), 64'd0);
    chk({tag, ".playing"},    64'(playing),      64'd0);
    chk({tag, ".song_done"},  64'(song_done),    64'd0);
    chk({tag, ".underrun"},   64'(underrun),     64'd0);
    chk({tag, ".note_ready"}, 64'(note_ready),   64'd0);
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; pause = 1'b0; lim = 23'd0;
    note_valid = 1'b0; note_bit = 1'b0; note_last = 1'b0;

    // ---------------- reset state
    step(2);
    chk_all_zero("rst");
    n_rst = 1'b1;
    step(1);

    // ---------------- basic song: lim=5, notes 1,0,1
    lim = 23'd5; note_valid = 1'b1; note_bit = 1'b1; note_last = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    chk("s1.cnt0",     64'(counter),    64'd0);
    chk("s1.playing",  64'(playing),    64'd1);
    chk("s1.rdy_off",  64'(note_ready), 64'd0);
    step(4);
    chk("s1.cnt_tick1", 64'(counter),    64'd4);
    chk("s1.rdy_tick1", 64'(note_ready), 64'd1);
    step(1);
    chk("s1.lane1",    64'(padded_notes), 64'b1);
    chk("s1.cnt_wrap", 64'(counter),      64'd0);
    note_bit = 1'b0;
    step(4);
    chk("s1.rdy_tick2", 64'(note_ready), 64'd1);
    step(1);
    chk("s1.lane2", 64'(padded_notes), 64'b10);
    note_bit = 1'b1; note_last = 1'b1;
    step(4);
    chk("s1.rdy_tick3", 64'(note_ready), 64'd1);
    step(1);
    chk("s1.lane3", 64'(padded_notes), 64'b101);
    note_last = 1'b0; note_valid = 1'b0;
    step(4);
    chk("s1.drain_rdy",  64'(note_ready), 64'd0);
    chk("s1.drain_undr", 64'(underrun),   64'd0);
    step(1);
    step(170);
    chk("s1.hit_t38", 64'(padded_notes), (64'd1 << 37) | (64'd1 << 35));
    step(10);
    chk("s1.hit_t40", 64'(padded_notes), 64'd1 << 37);
    step(5);
    chk("s1.done_early", 64'(song_done), 64'd0);
    chk("s1.play_t41",   64'(playing),   64'd1);
    step(5);
    chk("s1.done_pulse", 64'(song_done),    64'd1);
    chk("s1.done_play",  64'(playing),      64'd0);
    chk("s1.done_lane",  64'(padded_notes), 64'd0);
    chk("s1.done_cnt",   64'(counter),      64'd0);
    step(1);
    chk("s1.done_1cyc",  64'(song_done),    64'd0);

    // ---------------- pause hold, pause on tick, start ignored in PLAY
    lim = 23'd4; note_valid = 1'b1; note_bit = 1'b1;
    start = 1'b1; step(1); start = 1'b0;
    chk("p.cnt0", 64'(counter), 64'd0);
    step(2);
    chk("p.cnt2", 64'(counter), 64'd2);
    pause = 1'b1;
    step(10);
    chk("p.hold_cnt",  64'(counter),      64'd2);
    chk("p.hold_lane", 64'(padded_notes), 64'd0);
    chk("p.hold_play", 64'(playing),      64'd1);
    pause = 1'b0;
    step(1);
    chk("p.resume_cnt", 64'(counter), 64'd2);
    step(1);
    chk("p.tick_cnt", 64'(counter),    64'd3);
    chk("p.tick_rdy", 64'(note_ready), 64'd1);
    pause = 1'b1;
    #1;
    chk("p.pause_on_tick_rdy", 64'(note_ready), 64'd0);
    step(1);
    chk("p.pause_on_tick_lane", 64'(padded_notes), 64'd0);
    chk("p.pause_on_tick_cnt",  64'(counter),      64'd3);
    pause = 1'b0;
    step(1);
    chk("p.retick_rdy", 64'(note_ready), 64'd1);
    start = 1'b1; step(1); start = 1'b0;
    chk("p.start_ign_lane", 64'(padded_notes), 64'd1);
    chk("p.start_ign_play", 64'(playing),      64'd1);

    // ---------------- underrun: sticky until next start
    note_valid = 1'b0;
    step(3);
    chk("u.tick_rdy", 64'(note_ready), 64'd1);
    chk("u.before",   64'(underrun),   64'd0);
    step(1);
    chk("u.lane_rest", 64'(padded_notes), 64'b10);
    chk("u.set",       64'(underrun),     64'd1);
    note_valid = 1'b1; note_last = 1'b1;
    step(4);
    chk("u.lane_after", 64'(padded_notes), 64'b101);
    chk("u.sticky",     64'(underrun),     64'd1);
    note_last = 1'b0;
    step(156);
    chk("u.done",        64'(song_done), 64'd1);
    chk("u.sticky_done", 64'(underrun),  64'd1);

    // ---------------- clamp lim=0, lim change ignored, reset mid-drain
    lim = 23'd0; note_valid = 1'b1; note_bit = 1'b1; note_last = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    chk("c.undr_clr", 64'(underrun), 64'd0);
    chk("c.cnt0",     64'(counter),  64'd0);
    step(1);
    chk("c.cnt1", 64'(counter),    64'd1);
    chk("c.rdy",  64'(note_ready), 64'd1);
    lim = 23'd7;
    step(1);
    chk("c.wrap",  64'(counter),      64'd0);
    chk("c.lane1", 64'(padded_notes), 64'b1);
    step(1);
    chk("c.lim_chg_ign", 64'(note_ready), 64'd1);
    note_last = 1'b1; note_bit = 1'b0;
    step(1);
    chk("c.lane2", 64'(padded_notes), 64'b10);
    note_last = 1'b0;
    step(1);
    chk("c.drain_rdy", 64'(note_ready), 64'd0);
    step(1);
    chk("c.drain_lane", 64'(padded_notes), 64'b100);
    step(36);
    chk("c.pre_rst_lane", 64'(padded_notes), 64'd1 << 20);
    chk("c.pre_rst_play", 64'(playing),      64'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk_all_zero("arst");
    step(1);
    chk_all_zero("arst_hold");
    n_rst = 1'b1;
    step(3);
    chk("arst.no_done", 64'(song_done), 64'd0);
    chk("arst.idle",    64'(playing),   64'd0);

    // ---------------- restart after reset, lim=1 clamps to 2
    lim = 23'd1; note_bit = 1'b1;
    start = 1'b1; step(1); start = 1'b0;
    chk("r.cnt0", 64'(counter), 64'd0);
    chk("r.play", 64'(playing), 64'd1);
    step(1);
    chk("r.cnt1", 64'(counter),    64'd1);
    chk("r.rdy",  64'(note_ready), 64'd1);
    step(1);
    chk("r.wrap", 64'(counter),      64'd0);
    chk("r.lane", 64'(padded_notes), 64'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
